_event_latch: RTL

Sticky event-capture stage that sits directly upstream of the `_or` reduction. It detects per-bit events on `inputData`, masks them, and holds them in a pending register until software or a controller clears them through a valid/ready handshake. `pendingData` drives the `_or` stage's `inputData` bus. `anyPending` is a registered copy of the same reduction for local use.

---
 rtl/_event_latch.sv | 101 ++++++++++
 1 files changed

// File: rtl/_event_latch.sv
// _event_latch
// Sticky event-capture stage feeding the downstream _or reduction. Per-bit
// events (rising edge or level, chosen by EDGE_MODE) are masked and held in
// pendingData until cleared through a valid/ready handshake. Events on bits
// that are already pending raise a sticky overflow flag.
//
// Ports:
//   Clock        : single clock, rising-edge active
//   Reset        : synchronous, active-high
//   DigitSupply  : supply pair routed to downstream cells, unused here
//   inputData    : raw event lines
//   maskData     : per-bit enable for new sets
//   clearValid   : clear request
//   clearData    : bits to clear when the request is accepted
//   clearReady   : registered; clear can be accepted this cycle
//   pendingData  : sticky pending flags (drives _or inputData)
//   anyPending   : registered OR of pendingData
//   overflowData : sticky flag, event hit a bit that was already pending
module _event_latch #(
  parameter int unsigned INPUT_WIDTH = 1,
  parameter bit          EDGE_MODE   = 1'b1
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic [1:0]             DigitSupply,
  input  logic [INPUT_WIDTH-1:0] inputData,
  input  logic [INPUT_WIDTH-1:0] maskData,
  input  logic                   clearValid,
  input  logic [INPUT_WIDTH-1:0] clearData,
  output logic                   clearReady,
  output logic [INPUT_WIDTH-1:0] pendingData,
  output logic                   anyPending,
  output logic [INPUT_WIDTH-1:0] overflowData
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    CLEAR   = 2'd2
  } state_t;

  state_t                 state;
  state_t                 state_next;
  logic [INPUT_WIDTH-1:0] prev_data;
  logic [INPUT_WIDTH-1:0] raw;
  logic [INPUT_WIDTH-1:0] event_bits;
  logic [INPUT_WIDTH-1:0] clr;
  logic [INPUT_WIDTH-1:0] pending_next;
  logic [INPUT_WIDTH-1:0] overflow_next;
  logic                   accept;

  // Supply pins only pass through to downstream cells.
  logic supply_unused;
  assign supply_unused = ^DigitSupply;

  always_comb begin
    raw           = EDGE_MODE ? (inputData & ~prev_data) : inputData;
    event_bits    = raw & maskData;
    accept        = clearValid & clearReady;
    clr           = accept ? clearData : '0;
    // Set wins over clear; an event on a bit being cleared is not an overflow.
    pending_next  = (pendingData & ~clr) | event_bits;
    overflow_next = (overflowData & ~clr) | (event_bits & pendingData & ~clr);

    state_next = state;
    unique case (state)
      IDLE: begin
        if (accept)               state_next = CLEAR;
        else if (|event_bits)     state_next = PENDING;
      end
      PENDING: begin
        if (accept)               state_next = CLEAR;
      end
      CLEAR: begin
        // Look at the post-update flags so an event captured during CLEAR
        // never leaves the FSM in IDLE with a bit pending.
        state_next = (|pending_next) ? PENDING : IDLE;
      end
      default:                    state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state        <= IDLE;
      prev_data    <= inputData;
      pendingData  <= '0;
      overflowData <= '0;
      anyPending   <= 1'b0;
      clearReady   <= 1'b1;
    end else begin
      state        <= state_next;
      prev_data    <= inputData;
      pendingData  <= pending_next;
      overflowData <= overflow_next;
      anyPending   <= |pending_next;
      clearReady   <= (state_next != CLEAR);
    end
  end

endmodule
